// File: rtl/div_seq_pkg.sv
// div_seq shared definitions: FSM state codes, handshake levels,
// iteration count and reset polarity for the EX-stage divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic [5:0] DivIterations = 6'd32;

  localparam logic RstActive = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU) for the EX stage.
// Produces {remainder, quotient} with a ready flag and a stall request.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stallreq
);

  div_state_e  state_q;
  logic [64:0] work_q;
  logic [31:0] dvs_q;
  logic [5:0]  cnt_q;
  logic        neg1_q;
  logic        neg2_q;
  logic        sgn_q;
  logic [63:0] result_q;
  logic        ready_q;

  logic        go;
  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] diff_d;
  logic [64:0] work_d;
  logic [31:0] quo_d;
  logic [31:0] rem_d;

  assign go = (start == DivStart) && !annul;

  assign op1_abs = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
  assign op2_abs = (signed_div && opdata2[31]) ? -opdata2 : opdata2;

  // work_q: [64:33] partial remainder, [32:1] dividend, [0] quotient
  // bits shifted in from the bottom as the dividend shifts out the top.
  assign diff_d = work_q[64:32] - {1'b0, dvs_q};
  assign work_d = diff_d[32]
                ? {work_q[63:0], 1'b0}
                : {diff_d[31:0], work_q[31:0], 1'b1};

  assign quo_d = (sgn_q && (neg1_q ^ neg2_q))
               ? -work_q[31:0] : work_q[31:0];
  assign rem_d = (sgn_q && neg1_q)
               ? -work_q[64:33] : work_q[64:33];

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      state_q  <= DivFree;
      work_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          ready_q  <= DivResultNotReady;
          result_q <= '0;
          if (go) begin
            cnt_q <= '0;
            if (opdata2 == 32'd0) begin
              state_q <= DivByZero;
            end else begin
              state_q <= DivOn;
              work_q  <= {32'd0, op1_abs, 1'b0};
              dvs_q   <= op2_abs;
              neg1_q  <= opdata1[31];
              neg2_q  <= opdata2[31];
              sgn_q   <= signed_div;
            end
          end
        end
        DivByZero: begin
          // two cycles here so ready lands after the second edge
          if (annul) begin
            state_q <= DivFree;
          end else if (cnt_q == 6'd0) begin
            cnt_q <= 6'd1;
          end else begin
            state_q  <= DivEnd;
            result_q <= '0;
            ready_q  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul) begin
            state_q <= DivFree;
          end else if (cnt_q == DivIterations) begin
            state_q  <= DivEnd;
            result_q <= {rem_d, quo_d};
            ready_q  <= DivResultReady;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 6'd1;
          end
        end
        DivEnd: begin
          if (start == DivStop || annul) begin
            state_q  <= DivFree;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end
        end
        default: begin
          state_q <= DivFree;
        end
      endcase
    end
  end

  assign result   = result_q;
  assign ready    = ready_q;
  assign stallreq = start & ~annul & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results,
// divide-by-zero, annul, mid-run reset and held-start behaviour.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a division and wait (bounded) for ready.
  // cyc = edges after the launch edge T until ready, -1 on timeout.
  task automatic run_div(input logic s, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [63:0] res, output int cyc,
                         output int stalls, output logic stall0);
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    #1;
    stall0 = stallreq;
    cyc    = -1;
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready) begin
        cyc = k;
        break;
      end
      if (stallreq) stalls++;
    end
    res = result;
  endtask

  task automatic drop_start();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    annul = 1'b0;
    signed_div = 1'b0;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    tick();
    tick();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0", ready);
    end
    n_checks++;
    if (result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if (ready !== 1'b0 || stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: ready %b stall %b want 0 0",
               ready, stallreq);
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] res;
    int cyc, stalls;
    logic s0;
    run_div(1'b0, 32'd100, 32'd7, res, cyc, stalls, s0);
    n_checks++;
    if (s0 !== 1'b1) begin
      n_fail++;
      $display("FAIL u100_7_stall_rise: got %b want 1", s0);
    end
    n_checks++;
    if (cyc !== 33) begin
      n_fail++;
      $display("FAIL u100_7_latency: got %0d want 33", cyc);
    end
    n_checks++;
    if (stalls !== 33) begin
      n_fail++;
      $display("FAIL u100_7_stall_cycles: got %0d want 33", stalls);
    end
    n_checks++;
    if (res !== {32'h2, 32'hE}) begin
      n_fail++;
      $display("FAIL u100_7_result: got %h want %h",
               res, {32'h2, 32'hE});
    end
    n_checks++;
    if (stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL u100_7_stall_fall: got %b want 0", stallreq);
    end
    drop_start();
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, res, cyc, stalls, s0);
    n_checks++;
    if (res !== {32'hF, 32'h0FFF_FFFF}) begin
      n_fail++;
      $display("FAIL u_max_16: got %h want %h",
               res, {32'hF, 32'h0FFF_FFFF});
    end
    drop_start();
    run_div(1'b0, 32'hFFFF_FFF9, 32'h2, res, cyc, stalls, s0);
    n_checks++;
    if (res !== {32'h1, 32'h7FFF_FFFC}) begin
      n_fail++;
      $display("FAIL u_neg7_as_unsigned: got %h want %h",
               res, {32'h1, 32'h7FFF_FFFC});
    end
    drop_start();
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int cyc, stalls;
    logic s0;
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, res, cyc, stalls, s0);
    n_checks++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++;
      $display("FAIL s_m7_2: got %h want %h",
               res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    drop_start();
    run_div(1'b1, 32'h7, 32'hFFFF_FFFE, res, cyc, stalls, s0);
    n_checks++;
    if (res !== {32'h1, 32'hFFFF_FFFD}) begin
      n_fail++;
      $display("FAIL s_7_m2: got %h want %h",
               res, {32'h1, 32'hFFFF_FFFD});
    end
    drop_start();
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc, stalls, s0);
    n_checks++;
    if (res !== {32'h0, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL s_minint_m1: got %h want %h",
               res, {32'h0, 32'h8000_0000});
    end
    n_checks++;
    if (cyc !== 33) begin
      n_fail++;
      $display("FAIL s_minint_latency: got %0d want 33", cyc);
    end
    drop_start();
  endtask

  task automatic test_div_zero();
    logic [63:0] res;
    int cyc, stalls;
    logic s0;
    run_div(1'b1, 32'h1234_5678, 32'h0, res, cyc, stalls, s0);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL dz_latency: got %0d want 2", cyc);
    end
    n_checks++;
    if (res !== 64'd0) begin
      n_fail++;
      $display("FAIL dz_result: got %h want 0", res);
    end
    drop_start();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_back_free: ready %b want 0", ready);
    end
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int cyc, stalls, seen;
    logic s0;
    signed_div = 1'b0;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    for (int k = 0; k <= 10; k++) tick();
    annul = 1'b1;
    #1;
    n_checks++;
    if (stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_stall_drop: got %b want 0", stallreq);
    end
    tick();
    annul = 1'b0;
    start = 1'b0;
    #1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready) seen++;
      tick();
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL annul_no_ready: got %0d ready cycles want 0", seen);
    end
    run_div(1'b0, 32'd100, 32'd7, res, cyc, stalls, s0);
    n_checks++;
    if (res !== {32'h2, 32'hE} || cyc !== 33) begin
      n_fail++;
      $display("FAIL annul_rerun: got %h/%0d want %h/33",
               res, cyc, {32'h2, 32'hE});
    end
    drop_start();
  endtask

  task automatic test_rst_mid();
    logic [63:0] res;
    int cyc, stalls;
    logic s0;
    signed_div = 1'b0;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid: ready %b result %h want 0 0",
               ready, result);
    end
    rst = 1'b1;
    start = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: ready %b want 0", ready);
    end
    run_div(1'b0, 32'd1000, 32'd33, res, cyc, stalls, s0);
    n_checks++;
    if (res !== {32'd10, 32'd30} || cyc !== 33) begin
      n_fail++;
      $display("FAIL rst_mid_rerun: got %h/%0d want %h/33",
               res, cyc, {32'd10, 32'd30});
    end
    drop_start();
  endtask

  task automatic test_hold_end();
    logic [63:0] res;
    int cyc, stalls;
    logic s0;
    run_div(1'b1, 32'hFFFF_FC18, 32'd33, res, cyc, stalls, s0);
    n_checks++;
    if (res !== {32'hFFFF_FFF6, 32'hFFFF_FFE2}) begin
      n_fail++;
      $display("FAIL hold_result: got %h want %h",
               res, {32'hFFFF_FFF6, 32'hFFFF_FFE2});
    end
    opdata1 = 32'd5;
    opdata2 = 32'd1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (ready !== 1'b1 || result !== {32'hFFFF_FFF6, 32'hFFFF_FFE2}
          || stallreq !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable_%0d: ready %b stall %b result %h",
                 k, ready, stallreq, result);
      end
    end
    drop_start();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: ready %b want 0", ready);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_rst_mid();
    test_hold_end();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
